// File: rtl/video_stream_tx.sv
// Pixel FIFO feeding an Avalon-ST video source: one header beat per frame,
// then IMAGE_W*IMAGE_H pixel beats with column/row tracking and a frame counter.
module video_stream_tx #(
  parameter int unsigned IMAGE_W    = 640,
  parameter int unsigned IMAGE_H    = 480,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_red,
  input  logic [7:0]  in_green,
  input  logic [7:0]  in_blue,
  output logic        in_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [7:0]  frame_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 24;
  localparam int unsigned XW = 11;
  localparam int unsigned FW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_PIXELS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic [XW-1:0]   x_q, x_d;
  logic [XW-1:0]   y_q, y_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            push;
  logic            pop;
  logic            last_px;
  logic            last_ln;

  assign in_ready    = in_ready_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = frame_q;

  // State, pointers and counters; in_ready is a register so it never sees source_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_red, in_green, in_blue};
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_d      = frame_q;
    source_valid = 1'b0;
    source_data  = '0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    pop          = 1'b0;
    push         = in_valid && in_ready_q;
    last_px      = (x_q == XW'(IMAGE_W - 1));
    last_ln      = (y_q == XW'(IMAGE_H - 1));

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        source_valid = 1'b1;
        source_sop   = 1'b1;
        if (source_ready) state_d = ST_PIXELS;
      end
      ST_PIXELS: begin
        source_valid = (count_q != '0);
        if (source_valid) begin
          source_data = mem_q[rd_ptr_q];
          source_eop  = last_px && last_ln;
        end
        pop = source_valid && source_ready;
        if (pop) begin
          if (last_px) begin
            x_d = '0;
            if (last_ln) begin
              y_d     = '0;
              frame_d = frame_q + FW'(1);
              state_d = ST_IDLE;
            end else begin
              y_d = y_q + XW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    in_ready_d = (count_d != CW'(FIFO_DEPTH));
  end

endmodule

// File: doc/video_stream_tx.md
VIDEO_STREAM_TX -- requirements
Module: video_stream_tx

Interface
REQ-001 Parameter IMAGE_W, default 640, pixels per line.
REQ-002 Parameter IMAGE_H, default 480, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 8, pixel buffer entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  processed pixel present on in_red/in_green/in_blue.
REQ-007 in_red, in_green, in_blue  in  8 each  processed pixel components.
REQ-008 in_ready  out  1  block accepts pixel this cycle.
REQ-009 source_data  out  24  Avalon-ST video beat, {red, green, blue}, red in [23:16].
REQ-010 source_valid  out  1  beat valid.
REQ-011 source_ready  in  1  downstream sink accepts beat.
REQ-012 source_sop  out  1  first beat of packet.
REQ-013 source_eop  out  1  last beat of packet.
REQ-014 x  out  11  column of pixel currently presented on source_data.
REQ-015 y  out  11  row of pixel currently presented on source_data.
REQ-016 frame_count  out  8  completed frames, wraps 255->0.

Function
REQ-017 Input transfer: in_valid && in_ready; pixel written to FIFO.
REQ-018 in_ready SHALL equal !fifo_full, registered-state derived, no combinational path from source_ready; no write when full (pixel held by upstream).
REQ-019 Output transfer: source_valid && source_ready; source_valid SHALL NOT depend combinationally on source_ready.
REQ-020 While source_valid && !source_ready, source_data/sop/eop/x/y SHALL hold stable.
REQ-021 FSM states IDLE, HEADER, PIXELS.
- IDLE: source_valid=0; to HEADER when FIFO non-empty.
- HEADER: source_valid=1, source_data=24'h000000 (packet type 0), source_sop=1, source_eop=0; to PIXELS on transfer.
- PIXELS: source_valid = !fifo_empty; source_data = FIFO head; sop=0.
REQ-022 Each PIXELS transfer pops FIFO, increments x; at x==IMAGE_W-1, x->0 and y increments.
REQ-023 source_eop=1 exactly on beat x==IMAGE_W-1, y==IMAGE_H-1; on its transfer: x,y->0, frame_count+1, state->IDLE.
REQ-024 Simultaneous FIFO write and read in same cycle SHALL both occur; occupancy unchanged.
REQ-025 FIFO empty in PIXELS: source_valid=0, x/y held, no bubble beat emitted.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-027 Latency: pixel written into empty FIFO in PIXELS appears on source_data next cycle (1 cycle).
REQ-028 Header SHALL NOT pop FIFO; pixels arriving during IDLE/HEADER are buffered.

Reset
REQ-029 reset_n low: state=IDLE, FIFO empty, x=0, y=0, frame_count=0, source_valid=0, sop=0, eop=0, source_data=0, in_ready=0 while asserted, 1 on first cycle after release.
REQ-030 Reset mid-frame discards buffered pixels; next output after release starts with header beat.

Verification (IMAGE_W=4, IMAGE_H=2, FIFO_DEPTH=4)
REQ-031 Reset release, source_ready=1, 8 pixels 0x010101..0x080808 back-to-back -> header 0x000000 with sop, then 8 beats in order, eop on 0x080808, frame_count=1.
REQ-032 source_ready=0 during PIXELS -> FIFO fills, in_ready=0 after 4 accepts, source_data/x/y stable; release -> no pixel lost or duplicated.
REQ-033 Random in_valid and source_ready toggling over 3 frames -> output equals input order, exactly 3 sop and 3 eop, frame_count=3.
REQ-034 in_valid=0 mid-line at x=2 -> source_valid drops, x stays 2; resume -> continues at x=2.
REQ-035 reset_n pulsed low at x=1,y=1 -> all outputs per REQ-029 immediately; next frame begins with sop header.
REQ-036 Simultaneous push/pop with FIFO at occupancy 4 (full) and source_ready=1 -> in_ready=0 that cycle, occupancy 3 next cycle, in_ready=1.
